// File: rtl/pdp_mem_arbiter.sv
// Single-port memory arbiter for a PDP-8 style core: fetch, operand-read and
// write ports share one memory, with one transaction outstanding at a time.
module pdp_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  // Handshake: a requester raises req with stable addr/data and holds it until
  // its ack pulses for one cycle; req is only sampled while the arbiter is idle.
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_ack,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_ack,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  rd_timeout,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IFU  = 2'd1,
    G_EXRD = 2'd2,
    G_EXWR = 2'd3
  } grant_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t                r_state;
  state_t                w_state_nxt;
  grant_t                r_grant;
  grant_t                w_grant_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_starve;
  logic [CW-1:0]         r_wait_cnt;
  logic                  r_timeout;
  logic [DATA_WIDTH-1:0] r_ifu_data;
  logic [DATA_WIDTH-1:0] r_exec_data;
  logic                  w_any_req;
  logic                  w_ifu_force;
  logic                  w_wait_expired;

  assign w_any_req      = ifu_rd_req | exec_rd_req | exec_wr_req;
  assign w_ifu_force    = ifu_rd_req && (r_starve == 2'd2);
  assign w_wait_expired = (r_wait_cnt == CW'(TIMEOUT - 1));

  // Fixed priority with a fairness override once the fetch port has lost twice.
  always_comb begin
    w_grant_nxt = G_NONE;
    if (w_ifu_force)      w_grant_nxt = G_IFU;
    else if (exec_wr_req) w_grant_nxt = G_EXWR;
    else if (exec_rd_req) w_grant_nxt = G_EXRD;
    else if (ifu_rd_req)  w_grant_nxt = G_IFU;
  end

  always_comb begin
    w_addr_nxt = '0;
    case (w_grant_nxt)
      G_IFU:   w_addr_nxt = ifu_rd_addr;
      G_EXRD:  w_addr_nxt = exec_rd_addr;
      G_EXWR:  w_addr_nxt = exec_wr_addr;
      default: w_addr_nxt = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = (r_grant == G_EXWR) ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_rvalid || w_wait_expired) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, starvation tracking, wait timer and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant     <= G_NONE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_starve    <= 2'd0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_ifu_data  <= '0;
      r_exec_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_grant_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= (w_grant_nxt == G_EXWR) ? exec_wr_data : '0;
            if (w_grant_nxt == G_IFU)
              r_starve <= 2'd0;
            else if (ifu_rd_req && (r_starve != 2'd3))
              r_starve <= r_starve + 2'd1;
          end
        end
        S_ISSUE: r_wait_cnt <= '0;
        S_WAIT: begin
          if (mem_rvalid) begin
            if (r_grant == G_IFU) r_ifu_data  <= mem_rdata;
            else                  r_exec_data <= mem_rdata;
          end else if (w_wait_expired) begin
            r_timeout <= 1'b1;
            if (r_grant == G_IFU) r_ifu_data  <= '0;
            else                  r_exec_data <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ifu_rd_ack  = 1'b0;
    exec_rd_ack = 1'b0;
    exec_wr_ack = 1'b0;
    case (r_state)
      S_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = (r_grant == G_EXWR);
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      S_RESP: begin
        ifu_rd_ack  = (r_grant == G_IFU);
        exec_rd_ack = (r_grant == G_EXRD);
        exec_wr_ack = (r_grant == G_EXWR);
      end
      default: ;
    endcase
  end

  assign ifu_rd_data  = r_ifu_data;
  assign exec_rd_data = r_exec_data;
  assign rd_timeout   = r_timeout;
  assign dbg_state    = r_state;

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({ifu_rd_ack, exec_rd_ack, exec_wr_ack}));
  a_we_needs_req: assert property (@(posedge clk) disable iff (reset)
    mem_we |-> mem_req);

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Bench for pdp_mem_arbiter: directed port transactions, a behavioural memory,
// and a monitor that scores acks and memory commands against expected queues.
module tb_pdp_mem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 12;
  localparam int RW  = 2 + DW + 1;
  localparam int CMW = 1 + AW + DW;
  localparam int P_IFU  = 1;
  localparam int P_EXRD = 2;
  localparam int P_EXWR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifu_rd_req;
  logic [AW-1:0] ifu_rd_addr;
  logic [DW-1:0] ifu_rd_data;
  logic          ifu_rd_ack;
  logic          exec_rd_req;
  logic [AW-1:0] exec_rd_addr;
  logic [DW-1:0] exec_rd_data;
  logic          exec_rd_ack;
  logic          exec_wr_req;
  logic [AW-1:0] exec_wr_addr;
  logic [DW-1:0] exec_wr_data;
  logic          exec_wr_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          rd_timeout;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0]  exp_q[$];
  logic [CMW-1:0] cmd_q[$];

  logic [DW-1:0] mem [0:4095];
  int            rd_lat   = 1;
  bit            mem_mute = 1'b0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data;

  pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_rd_req   (ifu_rd_req),
    .ifu_rd_addr  (ifu_rd_addr),
    .ifu_rd_data  (ifu_rd_data),
    .ifu_rd_ack   (ifu_rd_ack),
    .exec_rd_req  (exec_rd_req),
    .exec_rd_addr (exec_rd_addr),
    .exec_rd_data (exec_rd_data),
    .exec_rd_ack  (exec_rd_ack),
    .exec_wr_req  (exec_wr_req),
    .exec_wr_addr (exec_wr_addr),
    .exec_wr_data (exec_wr_data),
    .exec_wr_ack  (exec_wr_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .rd_timeout   (rd_timeout),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] resp(input int p, input logic [DW-1:0] d, input logic t);
    return {p[1:0], d, t};
  endfunction

  // Behavioural memory: writes land on the issue cycle, reads return rd_lat cycles later.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o0010] = 12'o1234;
    mem[12'o0011] = 12'o5252;
    mem[12'o0020] = 12'o3333;
    mem[12'o0300] = 12'o4321;
    mem[12'o0400] = 12'o0707;
    mem[12'o0401] = 12'o1111;
    mem[12'o0402] = 12'o2222;
    mem[12'o0500] = 12'o6060;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_data;
        end
      end
      if (mem_req && mem_we) mem[mem_addr] = mem_wdata;
      if (mem_req && !mem_we && !mem_mute) begin
        pend_cnt  = rd_lat;
        pend_data = mem[mem_addr];
      end
    end
  end

  // Monitor: scores every ack and every memory command
  logic [2:0]    m_acks;
  logic [1:0]    m_port;
  logic [DW-1:0] m_data;
  always @(negedge clk) begin
    if (!reset) begin
      m_acks = {exec_wr_ack, exec_rd_ack, ifu_rd_ack};
      if (m_acks != 3'b000) begin
        chk("ack_onehot", $countones(m_acks), 1);
        if (exec_wr_ack) begin
          m_port = 2'd3; m_data = '0;
        end else if (exec_rd_ack) begin
          m_port = 2'd2; m_data = exec_rd_data;
        end else begin
          m_port = 2'd1; m_data = ifu_rd_data;
        end
        if (exp_q.size() == 0) chk("unexpected_ack", {29'd0, m_acks}, 0);
        else chk("resp", {m_port, m_data, rd_timeout}, exp_q.pop_front());
      end
      if (mem_req) begin
        if (cmd_q.size() == 0) chk("unexpected_mem_req", {31'd0, mem_req}, 0);
        else chk("mem_cmd", {mem_we, mem_addr, mem_wdata}, cmd_q.pop_front());
      end
      chk("we_without_req", {31'd0, mem_we & ~mem_req}, 0);
    end
  end

  // Driver: one request on a port, held until its ack; latency counts req cycle..ack cycle.
  task automatic port_txn(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int exp_cycles);
    int n;
    bit got;
    n   = 1;
    got = 1'b0;
    case (p)
      P_IFU:   begin ifu_rd_addr  = addr; ifu_rd_req  = 1'b1; end
      P_EXRD:  begin exec_rd_addr = addr; exec_rd_req = 1'b1; end
      default: begin exec_wr_addr = addr; exec_wr_data = wd; exec_wr_req = 1'b1; end
    endcase
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      case (p)
        P_IFU:   got = ifu_rd_ack;
        P_EXRD:  got = exec_rd_ack;
        default: got = exec_wr_ack;
      endcase
    end
    case (p)
      P_IFU:   ifu_rd_req  = 1'b0;
      P_EXRD:  exec_rd_req = 1'b0;
      default: exec_wr_req = 1'b0;
    endcase
    if (!got) chk($sformatf("ack_timeout_p%0d", p), {31'd0, got}, 1);
    else if (exp_cycles > 0) chk($sformatf("latency_p%0d", p), n, exp_cycles);
  endtask

  initial begin
    reset        = 1'b1;
    ifu_rd_req   = 1'b0;
    ifu_rd_addr  = '0;
    exec_rd_req  = 1'b0;
    exec_rd_addr = '0;
    exec_wr_req  = 1'b0;
    exec_wr_addr = '0;
    exec_wr_data = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_state", dbg_state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {ifu_rd_ack, exec_rd_ack, exec_wr_ack}, 0);
    chk("rst_data", {ifu_rd_data, exec_rd_data}, 0);
    chk("rst_timeout", rd_timeout, 0);
    reset = 1'b0;
    @(negedge clk);

    // write 0o7777 to 0o0200
    cmd_q.push_back({1'b1, 12'o0200, 12'o7777});
    exp_q.push_back(resp(P_EXWR, '0, 1'b0));
    port_txn(P_EXWR, 12'o0200, 12'o7777, 3);
    @(negedge clk);

    // fetch with 1-cycle memory latency
    cmd_q.push_back({1'b0, 12'o0010, 12'o0000});
    exp_q.push_back(resp(P_IFU, 12'o1234, 1'b0));
    port_txn(P_IFU, 12'o0010, '0, 4);
    @(negedge clk);

    // operand read-back of the earlier write
    cmd_q.push_back({1'b0, 12'o0200, 12'o0000});
    exp_q.push_back(resp(P_EXRD, 12'o7777, 1'b0));
    port_txn(P_EXRD, 12'o0200, '0, 4);
    @(negedge clk);

    // fetch with 3-cycle memory latency
    rd_lat = 3;
    cmd_q.push_back({1'b0, 12'o0011, 12'o0000});
    exp_q.push_back(resp(P_IFU, 12'o5252, 1'b0));
    port_txn(P_IFU, 12'o0011, '0, 6);
    rd_lat = 1;
    @(negedge clk);

    // contention: all three together
    cmd_q.push_back({1'b1, 12'o0600, 12'o1357});
    cmd_q.push_back({1'b0, 12'o0300, 12'o0000});
    cmd_q.push_back({1'b0, 12'o0020, 12'o0000});
    exp_q.push_back(resp(P_EXWR, '0, 1'b0));
    exp_q.push_back(resp(P_EXRD, 12'o4321, 1'b0));
    exp_q.push_back(resp(P_IFU, 12'o3333, 1'b0));
    fork
      port_txn(P_EXWR, 12'o0600, 12'o1357, 3);
      port_txn(P_EXRD, 12'o0300, '0, 0);
      port_txn(P_IFU, 12'o0020, '0, 0);
    join
    @(negedge clk);

    // starvation: exec read kept asserted; the fetch wins the third arbitration
    cmd_q.push_back({1'b0, 12'o0400, 12'o0000});
    cmd_q.push_back({1'b0, 12'o0401, 12'o0000});
    cmd_q.push_back({1'b0, 12'o0010, 12'o0000});
    cmd_q.push_back({1'b0, 12'o0402, 12'o0000});
    exp_q.push_back(resp(P_EXRD, 12'o0707, 1'b0));
    exp_q.push_back(resp(P_EXRD, 12'o1111, 1'b0));
    exp_q.push_back(resp(P_IFU, 12'o1234, 1'b0));
    exp_q.push_back(resp(P_EXRD, 12'o2222, 1'b0));
    fork
      port_txn(P_IFU, 12'o0010, '0, 0);
      begin
        port_txn(P_EXRD, 12'o0400, '0, 0);
        port_txn(P_EXRD, 12'o0401, '0, 0);
        port_txn(P_EXRD, 12'o0402, '0, 0);
      end
    join
    @(negedge clk);

    // reset in the second WAIT cycle; the late mem_rvalid must be ignored
    rd_lat = 3;
    cmd_q.push_back({1'b0, 12'o0500, 12'o0000});
    exec_rd_addr = 12'o0500;
    exec_rd_req  = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_wait_state", dbg_state, 2);
    reset       = 1'b1;
    exec_rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", dbg_state, 0);
    chk("abort_exec_data", exec_rd_data, 0);
    chk("abort_ifu_data", ifu_rd_data, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle", dbg_state, 0);
      chk("abort_no_ack", {ifu_rd_ack, exec_rd_ack, exec_wr_ack}, 0);
      chk("abort_exec_data_held", exec_rd_data, 0);
    end
    rd_lat = 1;

    // normal read to load nonzero data, then a read that times out
    cmd_q.push_back({1'b0, 12'o0300, 12'o0000});
    exp_q.push_back(resp(P_EXRD, 12'o4321, 1'b0));
    port_txn(P_EXRD, 12'o0300, '0, 4);
    @(negedge clk);
    mem_mute = 1'b1;
    cmd_q.push_back({1'b0, 12'o0300, 12'o0000});
    exp_q.push_back(resp(P_EXRD, 12'o0000, 1'b1));
    port_txn(P_EXRD, 12'o0300, '0, 18);
    mem_mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("timeout_sticky", rd_timeout, 1);

    // flag stays set across a successful fetch
    cmd_q.push_back({1'b0, 12'o0010, 12'o0000});
    exp_q.push_back(resp(P_IFU, 12'o1234, 1'b1));
    port_txn(P_IFU, 12'o0010, '0, 4);
    @(negedge clk);

    // reset clears the flag
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("timeout_cleared", rd_timeout, 0);
    chk("final_state", dbg_state, 0);
    repeat (2) @(negedge clk);

    chk("resp_queue_drained", exp_q.size(), 0);
    chk("cmd_queue_drained", cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
